// File: rtl/pass_occupancy_counter.sv
// pass_occupancy_counter
//   Counts people passing through one or more doorways, each watched by an
//   outer (b1) and an inner (b2) beam sensor. A lane recognises a complete
//   entry (outer, both, inner, clear) or exit (the mirror order). It then
//   emits a one-cycle pulse. The shared occupancy count moves by the net
//   number of entries minus exits and saturates at 0 and MAX_OCC.
//
// Ports
//   clk      system clock
//   reset    asynchronous active-high reset
//   b1       outer sensor per lane (asynchronous to clk)
//   b2       inner sensor per lane (asynchronous to clk)
//   clr      synchronous clear of count, ovf and unf
//   count    current occupancy
//   entry_p  one-cycle entry pulse per lane
//   exit_p   one-cycle exit pulse per lane
//   full     count == MAX_OCC (combinational)
//   ovf      sticky: an update tried to exceed MAX_OCC
//   unf      sticky: an update tried to go below zero
module pass_occupancy_counter #(
  parameter int LANES   = 2,
  parameter int CNT_W   = 8,
  parameter int MAX_OCC = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] b1,
  input  logic [LANES-1:0] b2,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic [LANES-1:0] entry_p,
  output logic [LANES-1:0] exit_p,
  output logic             full,
  output logic             ovf,
  output logic             unf
);

  localparam int DW = $clog2(LANES) + 2;
  localparam int SW = CNT_W + 2;
  localparam logic signed [SW-1:0] MAX_S = SW'(MAX_OCC);
  localparam logic [CNT_W-1:0]     MAX_C = CNT_W'(MAX_OCC);
  localparam logic signed [DW-1:0] ONE   = DW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_IN1, S_IN2, S_IN3, S_OUT1, S_OUT2, S_OUT3, S_WAIT
  } state_t;

  function automatic logic [CNT_W-1:0] sat_count(input logic signed [SW-1:0] v);
    logic [CNT_W-1:0] r;
    if (v[SW-1])
      r = '0;
    else if (v > MAX_S)
      r = MAX_C;
    else
      r = v[CNT_W-1:0];
    return r;
  endfunction

  // Stage p0/p1: two-flop synchronizers on every sensor bit
  logic [LANES-1:0] b1_p0, b1_p1, b2_p0, b2_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b1_p0 <= '0;
      b1_p1 <= '0;
      b2_p0 <= '0;
      b2_p1 <= '0;
    end else begin
      b1_p0 <= b1;
      b1_p1 <= b1_p0;
      b2_p0 <= b2;
      b2_p1 <= b2_p0;
    end
  end

  // Stage p2: per-lane direction FSMs, pulses and occupancy update
  state_t           state     [LANES];
  state_t           state_nxt [LANES];
  logic [LANES-1:0] entry_ev, exit_ev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) state[i] <= S_IDLE;
    end else begin
      for (int i = 0; i < LANES; i++) state[i] <= state_nxt[i];
    end
  end

  // OUT states mirror the IN states with the two sensor bits swapped.
  // WAIT absorbs any malformed pass until the doorway is clear again.
  always_comb begin
    entry_ev = '0;
    exit_ev  = '0;
    for (int i = 0; i < LANES; i++) begin
      state_nxt[i] = state[i];
      case (state[i])
        S_IDLE:
          case ({b1_p1[i], b2_p1[i]})
            2'b10:   state_nxt[i] = S_IN1;
            2'b01:   state_nxt[i] = S_OUT1;
            2'b11:   state_nxt[i] = S_WAIT;
            default: state_nxt[i] = S_IDLE;
          endcase
        S_IN1:
          case ({b1_p1[i], b2_p1[i]})
            2'b11:   state_nxt[i] = S_IN2;
            2'b00:   state_nxt[i] = S_IDLE;
            2'b01:   state_nxt[i] = S_WAIT;
            default: state_nxt[i] = S_IN1;
          endcase
        S_IN2:
          case ({b1_p1[i], b2_p1[i]})
            2'b01:   state_nxt[i] = S_IN3;
            2'b10:   state_nxt[i] = S_IN1;
            2'b00:   state_nxt[i] = S_WAIT;
            default: state_nxt[i] = S_IN2;
          endcase
        S_IN3:
          case ({b1_p1[i], b2_p1[i]})
            2'b00: begin
              state_nxt[i] = S_IDLE;
              entry_ev[i]  = 1'b1;
            end
            2'b11:   state_nxt[i] = S_IN2;
            2'b10:   state_nxt[i] = S_WAIT;
            default: state_nxt[i] = S_IN3;
          endcase
        S_OUT1:
          case ({b1_p1[i], b2_p1[i]})
            2'b11:   state_nxt[i] = S_OUT2;
            2'b00:   state_nxt[i] = S_IDLE;
            2'b10:   state_nxt[i] = S_WAIT;
            default: state_nxt[i] = S_OUT1;
          endcase
        S_OUT2:
          case ({b1_p1[i], b2_p1[i]})
            2'b10:   state_nxt[i] = S_OUT3;
            2'b01:   state_nxt[i] = S_OUT1;
            2'b00:   state_nxt[i] = S_WAIT;
            default: state_nxt[i] = S_OUT2;
          endcase
        S_OUT3:
          case ({b1_p1[i], b2_p1[i]})
            2'b00: begin
              state_nxt[i] = S_IDLE;
              exit_ev[i]   = 1'b1;
            end
            2'b11:   state_nxt[i] = S_OUT2;
            2'b01:   state_nxt[i] = S_WAIT;
            default: state_nxt[i] = S_OUT3;
          endcase
        S_WAIT:
          if ({b1_p1[i], b2_p1[i]} == 2'b00) state_nxt[i] = S_IDLE;
        default: state_nxt[i] = S_IDLE;
      endcase
    end
  end

  // Net change this cycle; entries on one lane cancel exits on another.
  logic signed [DW-1:0] delta;
  logic signed [SW-1:0] sum;

  always_comb begin
    delta = '0;
    for (int i = 0; i < LANES; i++) begin
      if (entry_ev[i]) delta = delta + ONE;
      if (exit_ev[i])  delta = delta - ONE;
    end
    sum = $signed({2'b00, count}) + SW'(delta);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      entry_p <= '0;
      exit_p  <= '0;
    end else begin
      entry_p <= entry_ev;
      exit_p  <= exit_ev;
      // clr wins over any event finishing on the same edge
      if (clr) begin
        count <= '0;
        ovf   <= 1'b0;
        unf   <= 1'b0;
      end else begin
        count <= sat_count(sum);
        if (sum > MAX_S) ovf <= 1'b1;
        if (sum[SW-1])   unf <= 1'b1;
      end
    end
  end

  assign full = (count == MAX_C);

endmodule

// File: tb/tb_pass_occupancy_counter.sv
// tb_pass_occupancy_counter
//   Bench for pass_occupancy_counter. It uses a table of held sensor phases
//   with expected outcomes and hand sequences for latency, simultaneity,
//   saturation, clear and reset corners. A randomized run is compared against
//   a path-position model of each doorway.
module tb_pass_occupancy_counter;
  localparam int LANES   = 2;
  localparam int CNT_W   = 8;
  localparam int MAX_OCC = 10;

  logic             clk   = 1'b0;
  logic             reset = 1'b0;
  logic             clr   = 1'b0;
  logic [LANES-1:0] b1    = '0;
  logic [LANES-1:0] b2    = '0;
  logic [CNT_W-1:0] count;
  logic [LANES-1:0] entry_p, exit_p;
  logic             full, ovf, unf;

  pass_occupancy_counter #(.LANES(LANES), .CNT_W(CNT_W), .MAX_OCC(MAX_OCC)) dut (
    .clk(clk), .reset(reset), .b1(b1), .b2(b2), .clr(clr),
    .count(count), .entry_p(entry_p), .exit_p(exit_p),
    .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;
  int en_seen, ex_seen, both_seen;

  typedef struct {
    logic [1:0] b1;
    logic [1:0] b2;
    logic       clr;
    int         hold;
    int         cnt;
    int         en;
    int         ex;
    logic       ovf;
    logic       unf;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    en_seen   += $countones(entry_p);
    ex_seen   += $countones(exit_p);
    both_seen += int'(entry_p != '0 && exit_p != '0);
  endtask

  task automatic add(input logic [1:0] vb1, input logic [1:0] vb2, input logic vc,
                     input int h, input int c, input int e, input int x,
                     input logic o, input logic u);
    vec_t v;
    v.b1 = vb1; v.b2 = vb2; v.clr = vc; v.hold = h;
    v.cnt = c; v.en = e; v.ex = x; v.ovf = o; v.unf = u;
    tbl.push_back(v);
  endtask

  // Sensor pair {b1,b2} at phase p of a walk: 1 = entry, 2 = exit, else idle
  function automatic logic [1:0] path(input int k, input int p);
    logic [1:0] r;
    r = 2'b00;
    if (k == 1)
      case (p) 0: r = 2'b10; 1: r = 2'b11; 2: r = 2'b01; default: r = 2'b00; endcase
    else if (k == 2)
      case (p) 0: r = 2'b01; 1: r = 2'b11; 2: r = 2'b10; default: r = 2'b00; endcase
    return r;
  endfunction

  task automatic run_paths(input int k0, input int k1);
    logic [1:0] v0, v1;
    en_seen = 0; ex_seen = 0; both_seen = 0;
    for (int p = 0; p < 4; p++) begin
      v0 = path(k0, p);
      v1 = path(k1, p);
      b1 = {v1[1], v0[1]};
      b2 = {v1[0], v0[0]};
      repeat (4) tick();
    end
  endtask

  task automatic check_all(input string tag, input int c, input int o, input int u);
    check({tag, "_count"}, int'(count), c);
    check({tag, "_ovf"}, int'(ovf), o);
    check({tag, "_unf"}, int'(unf), u);
    check({tag, "_full"}, int'(full), int'(c == MAX_OCC));
  endtask

  // Reference model: each lane tracks how far along an entry or exit path it
  // is (position 1..3), or that the pass went wrong and it waits for clear.
  int         m_dir   [LANES];
  int         m_pos   [LANES];
  bit         m_abort [LANES];
  logic [1:0] m_d1    [LANES];
  logic [1:0] m_d2    [LANES];
  int         m_cnt;
  bit         m_ovf, m_unf;
  logic [LANES-1:0] m_en, m_ex;

  function automatic logic [1:0] pv(input int dir, input int p);
    if (p == 2) return 2'b11;
    if (p == 1) return (dir > 0) ? 2'b10 : 2'b01;
    return (dir > 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      m_dir[i] = 0; m_pos[i] = 0; m_abort[i] = 0; m_d1[i] = 2'b00; m_d2[i] = 2'b00;
    end
    m_cnt = 0; m_ovf = 0; m_unf = 0; m_en = '0; m_ex = '0;
  endtask

  task automatic lane_step(input int i, input logic [1:0] v, output int ev);
    ev = 0;
    if (m_abort[i]) begin
      if (v == 2'b00) m_abort[i] = 0;
    end else if (m_pos[i] == 0) begin
      if (v == 2'b10) begin m_dir[i] = 1; m_pos[i] = 1; end
      else if (v == 2'b01) begin m_dir[i] = -1; m_pos[i] = 1; end
      else if (v == 2'b11) m_abort[i] = 1;
    end else if (v == 2'b00) begin
      if (m_pos[i] == 3) ev = m_dir[i];
      if (m_pos[i] == 2) m_abort[i] = 1;
      m_pos[i] = 0;
    end else if (v == pv(m_dir[i], m_pos[i])) begin
    end else if (m_pos[i] < 3 && v == pv(m_dir[i], m_pos[i] + 1)) begin
      m_pos[i]++;
    end else if (m_pos[i] > 1 && v == pv(m_dir[i], m_pos[i] - 1)) begin
      m_pos[i]--;
    end else begin
      m_abort[i] = 1;
      m_pos[i] = 0;
    end
  endtask

  // One clock edge: lanes act on raw values from two edges earlier.
  task automatic model_edge(input logic [LANES-1:0] rb1, input logic [LANES-1:0] rb2,
                            input logic rclr);
    int ev, delta, s;
    delta = 0; m_en = '0; m_ex = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_step(i, m_d2[i], ev);
      m_d2[i] = m_d1[i];
      m_d1[i] = {rb1[i], rb2[i]};
      if (ev > 0) begin m_en[i] = 1'b1; delta++; end
      if (ev < 0) begin m_ex[i] = 1'b1; delta--; end
    end
    s = m_cnt + delta;
    if (rclr) begin
      m_cnt = 0; m_ovf = 0; m_unf = 0;
    end else begin
      if (s > MAX_OCC) m_ovf = 1;
      if (s < 0) m_unf = 1;
      m_cnt = (s < 0) ? 0 : (s > MAX_OCC) ? MAX_OCC : s;
    end
  endtask

  initial begin
    logic [LANES-1:0] rb1, rb2;
    logic             rc;
    logic [1:0]       v;
    int               r;

    //  b1     b2     clr hold cnt en ex ovf unf
    add(2'b00, 2'b01, 0, 4, 1, 0, 0, 0, 0);   // exit lane 0 from count 1
    add(2'b01, 2'b01, 0, 4, 1, 0, 0, 0, 0);
    add(2'b01, 2'b00, 0, 4, 1, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 4, 0, 0, 1, 0, 0);
    add(2'b00, 2'b01, 0, 4, 0, 0, 0, 0, 0);   // exit at zero: underflow
    add(2'b01, 2'b01, 0, 4, 0, 0, 0, 0, 0);
    add(2'b01, 2'b00, 0, 4, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 4, 0, 0, 1, 0, 1);
    add(2'b01, 2'b00, 0, 4, 0, 0, 0, 0, 1);   // pedestrian 10,01,00
    add(2'b00, 2'b01, 0, 4, 0, 0, 0, 0, 1);
    add(2'b00, 2'b00, 0, 4, 0, 0, 0, 0, 1);
    add(2'b00, 2'b01, 0, 4, 0, 0, 0, 0, 1);   // pedestrian 01,10,00
    add(2'b01, 2'b00, 0, 4, 0, 0, 0, 0, 1);
    add(2'b00, 2'b00, 0, 4, 0, 0, 0, 0, 1);
    add(2'b01, 2'b00, 0, 4, 0, 0, 0, 0, 1);   // back-up 10,11,10,11,01,00
    add(2'b01, 2'b01, 0, 4, 0, 0, 0, 0, 1);
    add(2'b01, 2'b00, 0, 4, 0, 0, 0, 0, 1);
    add(2'b01, 2'b01, 0, 4, 0, 0, 0, 0, 1);
    add(2'b00, 2'b01, 0, 4, 0, 0, 0, 0, 1);
    add(2'b00, 2'b00, 0, 4, 1, 1, 0, 0, 1);
    add(2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0);   // clear
    add(2'b00, 2'b00, 0, 2, 0, 0, 0, 0, 0);
    add(2'b10, 2'b00, 0, 4, 0, 0, 0, 0, 0);   // entry on lane 1
    add(2'b10, 2'b10, 0, 4, 0, 0, 0, 0, 0);
    add(2'b00, 2'b10, 0, 4, 0, 0, 0, 0, 0);
    add(2'b00, 2'b00, 0, 4, 1, 1, 0, 0, 0);

    // Reset asserted between edges takes effect at once
    #1 reset = 1'b1;
    #2;
    check_all("reset", 0, 0, 0);
    check("reset_pulses", int'({entry_p, exit_p}), 0);
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b0;
    tick();
    check_all("post_reset", 0, 0, 0);

    // Entry latency: pulse and count appear on the third edge after 00
    b1 = 2'b01; b2 = 2'b00; repeat (4) tick();
    b1 = 2'b01; b2 = 2'b01; repeat (4) tick();
    b1 = 2'b00; b2 = 2'b01; repeat (4) tick();
    b1 = 2'b00; b2 = 2'b00;
    tick();
    check("lat_e1_entry", int'(entry_p), 0);
    tick();
    check("lat_e2_entry", int'(entry_p), 0);
    check("lat_e2_count", int'(count), 0);
    tick();
    check("lat_e3_entry", int'(entry_p), 1);
    check("lat_e3_count", int'(count), 1);
    tick();
    check("lat_e4_entry", int'(entry_p), 0);
    check("lat_e4_count", int'(count), 1);

    // Table of held phases
    foreach (tbl[i]) begin
      b1 = tbl[i].b1; b2 = tbl[i].b2; clr = tbl[i].clr;
      en_seen = 0; ex_seen = 0;
      repeat (tbl[i].hold) tick();
      clr = 1'b0;
      check_all($sformatf("row%0d", i), tbl[i].cnt, tbl[i].ovf, tbl[i].unf);
      check($sformatf("row%0d_entries", i), en_seen, tbl[i].en);
      check($sformatf("row%0d_exits", i), ex_seen, tbl[i].ex);
    end

    // Simultaneous entry/exit cancel, then saturation at the ceiling
    clr = 1'b1; tick(); clr = 1'b0;
    check_all("clr0", 0, 0, 0);
    run_paths(1, 1); run_paths(1, 1); run_paths(1, 0);
    check_all("five", 5, 0, 0);
    run_paths(1, 2);
    check("cancel_entries", en_seen, 1);
    check("cancel_exits", ex_seen, 1);
    check("cancel_same_cycle", both_seen, 1);
    check_all("cancel", 5, 0, 0);
    run_paths(1, 1); run_paths(1, 1);
    check_all("max_minus1", MAX_OCC - 1, 0, 0);
    run_paths(1, 1);
    check("sat_entries", en_seen, 2);
    check_all("sat", MAX_OCC, 1, 0);

    // clr at count 7 with ovf set; an entry finishing on the clr edge is lost
    run_paths(0, 2); run_paths(2, 2);
    check_all("seven", 7, 1, 0);
    b1 = 2'b01; b2 = 2'b00; repeat (4) tick();
    b1 = 2'b01; b2 = 2'b01; repeat (4) tick();
    b1 = 2'b00; b2 = 2'b01; repeat (4) tick();
    b1 = 2'b00; b2 = 2'b00;
    tick(); tick();
    check("pre_clr_count", int'(count), 7);
    clr = 1'b1; tick(); clr = 1'b0;
    check_all("clr_evt", 0, 0, 0);
    tick();
    check_all("clr_evt_after", 0, 0, 0);

    // Reset while a lane sits in IN2 aborts the pass
    run_paths(1, 0);
    check_all("pre_rst", 1, 0, 0);
    b1 = 2'b01; b2 = 2'b00; repeat (4) tick();
    b1 = 2'b01; b2 = 2'b01; repeat (4) tick();
    #3 reset = 1'b1;
    #1;
    check_all("mid_rst", 0, 0, 0);
    check("mid_rst_pulses", int'({entry_p, exit_p}), 0);
    #2 reset = 1'b0;
    en_seen = 0; ex_seen = 0;
    b1 = 2'b00; b2 = 2'b01; repeat (4) tick();
    b1 = 2'b00; b2 = 2'b00; repeat (4) tick();
    check("abort_entries", en_seen, 0);
    check("abort_exits", ex_seen, 0);
    check_all("abort", 0, 0, 0);
    run_paths(1, 0);
    check("fresh_entries", en_seen, 1);
    check_all("fresh", 1, 0, 0);

    // Randomized walks against the model
    b1 = '0; b2 = '0; clr = 1'b0;
    #3 reset = 1'b1;
    #3 reset = 1'b0;
    model_reset();
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < LANES; i++) begin
        v = {b1[i], b2[i]};
        r = $urandom_range(0, 99);
        if (r < 30) v = v ^ (2'b01 << $urandom_range(0, 1));
        else if (r < 33) v = 2'($urandom_range(0, 3));
        b1[i] = v[1];
        b2[i] = v[0];
      end
      clr = ($urandom_range(0, 79) == 0);
      rb1 = b1; rb2 = b2; rc = clr;
      tick();
      model_edge(rb1, rb2, rc);
      check("rnd_count", int'(count), m_cnt);
      check("rnd_entry", int'(entry_p), int'(m_en));
      check("rnd_exit", int'(exit_p), int'(m_ex));
      check("rnd_flags", int'({ovf, unf, full}), int'({m_ovf, m_unf, (m_cnt == MAX_OCC)}));
    end
    clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
